// File: rtl/imm_gen_pkg.sv
// Shared encodings for the immediate-generator pipeline: the 3-bit format
// select values and the matching format enum.
package imm_gen_pkg;

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;

  typedef enum logic [2:0] {
    FmtI = SRC_I,
    FmtS = SRC_S,
    FmtB = SRC_B,
    FmtU = SRC_U,
    FmtJ = SRC_J
  } fmt_e;

  // Encodings 101..111 carry no format.
  function automatic logic src_is_legal(input logic [2:0] src);
    return src <= SRC_J;
  endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational immediate extraction and sign extension. The input is the
// instruction with its opcode stripped: inm[k] = instr[k+7].
module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [24:0]     inm,
  input  logic [2:0]      src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  // Build the 32-bit immediate, already sign-extended to bit 31.
  always_comb begin
    imm32   = '0;
    illegal = !src_is_legal(src);
    case (src)
      SRC_I:   imm32 = {{20{inm[24]}}, inm[24:13]};
      SRC_S:   imm32 = {{20{inm[24]}}, inm[24:18], inm[4:0]};
      SRC_B:   imm32 = {{19{inm[24]}}, inm[24], inm[0], inm[23:18], inm[4:1], 1'b0};
      SRC_U:   imm32 = {inm[24:5], 12'b0};
      SRC_J:   imm32 = {{11{inm[24]}}, inm[24], inm[12:5], inm[13], inm[23:14], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Bit 31 is the sign for every format, including U on RV64.
  if (XLEN > 32) begin : gen_wide
    assign imm = {{(XLEN - 32){imm32[31]}}, imm32};
  end else begin : gen_narrow
    assign imm = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator. S1 holds the raw request, S2
// holds the decoded immediate. Optional error reporting (out_err, err_cnt)
// is enabled by defining IMM_GEN_ERR_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      inm,
  input  logic [2:0]       src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ERR_EN
  ,
  output logic             out_err,
  output logic [15:0]      err_cnt
`endif
);

  logic             s1_valid_q;
  logic [24:0]      s1_inm_q;
  logic [2:0]       s1_src_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [XLEN-1:0]  s2_imm_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_err_q;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  logic             s2_load;
  logic             s1_advance;

  // S2 can take a new entry when empty or draining this cycle; the ready
  // path from out_ready is combinational so a full pipe never bubbles.
  assign s2_load    = !s2_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_load;
  assign in_ready   = !s1_valid_q || s1_advance;

  imm_gen_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .inm    (s1_inm_q),
    .src    (s1_src_q),
    .imm    (dec_imm),
    .illegal(dec_illegal)
  );

  // Stage 1: capture the raw request on an input handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_inm_q   <= '0;
      s1_src_q   <= '0;
      s1_tag_q   <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_inm_q <= inm;
        s1_src_q <= src;
        s1_tag_q <= in_tag;
      end
    end
  end

  // Stage 2: capture the decoded result; data only moves with a real entry
  // so outputs hold still while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_tag_q   <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_imm_q <= dec_imm;
        s2_tag_q <= s1_tag_q;
        s2_err_q <= dec_illegal;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign imm       = s2_imm_q;
  assign out_tag   = s2_tag_q;

`ifdef IMM_GEN_ERR_EN
  logic [15:0] err_cnt_q;

  // Count illegal requests as they are delivered, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign out_err = s2_err_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_err;
  assign unused_err = s2_err_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share
// stimulus; results are checked against a field-arithmetic reference model
// through an in-order scoreboard.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready64;
  logic [24:0] inm;
  logic [2:0]  src;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_valid64;
  logic        out_ready;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [3:0]  out_tag;
  logic [3:0]  out_tag64;
`ifdef IMM_GEN_ERR_EN
  logic        out_err;
  logic        out_err64;
  logic [15:0] err_cnt;
  logic [15:0] err_cnt64;
  int          exp_err_cnt;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(
    .XLEN (32),
    .TAG_W(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inm      (inm),
    .src      (src),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .imm      (imm32),
    .out_tag  (out_tag)
`ifdef IMM_GEN_ERR_EN
    ,
    .out_err  (out_err),
    .err_cnt  (err_cnt)
`endif
  );

  imm_gen_pipe #(
    .XLEN (64),
    .TAG_W(4)
  ) dut64 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready64),
    .inm      (inm),
    .src      (src),
    .in_tag   (in_tag),
    .out_valid(out_valid64),
    .out_ready(out_ready),
    .imm      (imm64),
    .out_tag  (out_tag64)
`ifdef IMM_GEN_ERR_EN
    ,
    .out_err  (out_err64),
    .err_cnt  (err_cnt64)
`endif
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_del  = 0;
  bit          last_acc;
  bit          held_valid = 1'b0;
  logic [31:0] held_imm;
  logic [3:0]  held_tag;

  logic [63:0] exp_imm_q[$];
  logic [3:0]  exp_tag_q[$];
  bit          exp_err_q[$];

  // Reference: rebuild the instruction and assemble each immediate from its
  // architectural fields, with the sign taken from instr[31].
  function automatic logic [63:0] ref_imm(input logic [24:0] i_inm, input logic [2:0] i_src);
    logic [31:0] ins;
    logic [63:0] s;
    logic [63:0] r;
    ins = {i_inm, 7'b0};
    s   = {64{ins[31]}};
    case (i_src)
      3'd0: r = (s << 11) | 64'(ins[30:20]);
      3'd1: r = (s << 11) | (64'(ins[30:25]) << 5) | 64'(ins[11:7]);
      3'd2: r = (s << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      3'd3: r = (s << 31) | (64'(ins[30:12]) << 12);
      3'd4: r = (s << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
                | (64'(ins[30:21]) << 1);
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One cycle: inputs were driven just after the previous edge. Score the
  // handshakes that will happen at the coming edge, then advance.
  task automatic tick();
    bit          acc;
    bit          del;
    logic [63:0] e_imm;
    logic [3:0]  e_tag;
    bit          e_err;
    #1;
    if (held_valid) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_imm", 64'(imm32), 64'(held_imm));
      chk("stall_tag", 64'(out_tag), 64'(held_tag));
    end
`ifdef IMM_GEN_ERR_EN
    chk("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
    chk("err_cnt64", 64'(err_cnt64), 64'(exp_err_cnt));
`endif
    held_valid = out_valid && !out_ready;
    held_imm   = imm32;
    held_tag   = out_tag;
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    if (del) begin
      if (exp_imm_q.size() == 0) begin
        chk("unexpected_out", 64'(out_tag), 64'hDEAD);
      end else begin
        e_imm = exp_imm_q.pop_front();
        e_tag = exp_tag_q.pop_front();
        e_err = exp_err_q.pop_front();
        n_del++;
        chk("imm32", 64'(imm32), 64'(e_imm[31:0]));
        chk("imm64", imm64, e_imm);
        chk("tag", 64'(out_tag), 64'(e_tag));
        chk("valid64", 64'(out_valid64), 64'd1);
        chk("tag64", 64'(out_tag64), 64'(e_tag));
`ifdef IMM_GEN_ERR_EN
        chk("out_err", 64'(out_err), 64'(e_err));
        chk("out_err64", 64'(out_err64), 64'(e_err));
        if (e_err && exp_err_cnt < 65535) exp_err_cnt++;
`endif
      end
    end
    if (acc) begin
      exp_imm_q.push_back(ref_imm(inm, src));
      exp_tag_q.push_back(in_tag);
      exp_err_q.push_back(src > 3'd4);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge with whatever handshake is being driven; nothing is
  // scored for that cycle since reset wins.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    in_valid   = 1'b0;
    held_valid = 1'b0;
    exp_imm_q.delete();
    exp_tag_q.delete();
    exp_err_q.delete();
`ifdef IMM_GEN_ERR_EN
    exp_err_cnt = 0;
`endif
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(imm32), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic directed(input string name, input logic [31:0] instr, input logic [2:0] s,
                          input logic [3:0] t, input logic [31:0] e32, input logic [63:0] e64);
    in_valid  = 1'b1;
    inm       = instr[31:7];
    src       = s;
    in_tag    = t;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk({name, "_latency"}, 64'(out_valid), 64'd1);
    chk({name, "_32"}, 64'(imm32), 64'(e32));
    chk({name, "_64"}, imm64, e64);
`ifdef IMM_GEN_ERR_EN
    chk({name, "_err"}, 64'(out_err), 64'(s > 3'd4));
`endif
    tick();
  endtask

  initial begin
    bit saw_full;
    int sent;
    reset     = 1'b0;
    in_valid  = 1'b0;
    inm       = '0;
    src       = '0;
    in_tag    = '0;
    out_ready = 1'b1;
`ifdef IMM_GEN_ERR_EN
    exp_err_cnt = 0;
`endif
    @(posedge clk);
    #1;
    do_reset();

    directed("addi_m1", 32'hFFF00093, 3'b000, 4'h1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    directed("bne_m4", 32'hFE000EE3, 3'b010, 4'h2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    directed("lui_pos", 32'h123450B7, 3'b011, 4'h3, 32'h12345000, 64'h0000000012345000);
    directed("lui_neg", 32'h800000B7, 3'b011, 4'h4, 32'h80000000, 64'hFFFFFFFF80000000);
    directed("illegal", 32'hFFFFFFFF, 3'b110, 4'h5, 32'h0, 64'h0);
    tick();

    // Eight back-to-back requests with the consumer stalled in cycles 3..6.
    saw_full = 1'b0;
    sent     = 0;
    for (int c = 0; c < 40 && (sent < 8 || exp_imm_q.size() > 0); c++) begin
      in_valid  = (sent < 8);
      inm       = 25'($urandom);
      src       = 3'($urandom_range(0, 4));
      in_tag    = 4'(sent);
      out_ready = !(c >= 3 && c <= 6);
      tick();
      if (in_valid && !last_acc) saw_full = 1'b1;
      if (last_acc) sent++;
    end
    in_valid = 1'b0;
    chk("b2b_backpressure_seen", 64'(saw_full), 64'd1);
    chk("b2b_all_sent", 64'(sent), 64'd8);
    chk("b2b_drained", 64'(exp_imm_q.size()), 64'd0);

    // Reset with two requests in flight and a third presented during reset.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      inm      = 25'($urandom);
      src      = 3'd0;
      in_tag   = 4'(4'hA + i);
      tick();
    end
    in_valid = 1'b1;
    in_tag   = 4'hC;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("post_reset_idle", 64'(out_valid), 64'd0);
      tick();
    end

    // Random traffic on both ports, every format including illegal ones.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      inm       = 25'($urandom);
      src       = 3'($urandom_range(0, 7));
      in_tag    = 4'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_imm_q.size() > 0; c++) tick();
    chk("final_drain", 64'(exp_imm_q.size()), 64'd0);
    chk("deliveries_seen", 64'(n_del > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, 32, output data width; legal values 32 or 64.
REQ-002 Parameter TAG_W, 4, width of the sideband tag carried alongside each request.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 inm  input  25  instruction bits [31:7]; inm[k] = instr[k+7].
REQ-008 src  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J; 101-111 illegal.
REQ-009 in_tag  input  TAG_W  opaque sideband tag.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 imm  output  XLEN  sign-extended immediate.
REQ-013 out_tag  output  TAG_W  in_tag of the same request.

Function
REQ-014 Two-stage pipeline: S1 registers inm/src/tag; S2 registers the decoded immediate/tag; latency 2 cycles at out_ready=1; throughput 1 per cycle.
REQ-015 Transfer occurs on valid&&ready at either port; order preserved, no drop, no duplication.
REQ-016 S2 loads when S2 empty or out_ready=1; S1 loads when S1 empty or S1 advances; in_ready = !s1_valid || s1_advance (combinational path from out_ready allowed).
REQ-017 Simultaneous accept and deliver at full occupancy: both occur in the same cycle, with no bubble.
REQ-018 Decode, 32-bit value before extension: I {inm[24:13]}; S {inm[24:18],inm[4:0]}; B {inm[24],inm[0],inm[23:18],inm[4:1],0}; U {inm[24:5],12'b0}; J {inm[24],inm[12:5],inm[13],inm[23:14],0}.
REQ-019 I/S/B/J: sign-extend from the immediate MSB (inm[24]) to XLEN; U: sign-extend bit 31 to XLEN (RV64 semantics).
REQ-020 Illegal src: imm = 0 and the request still flows through the pipeline.
REQ-021 imm, out_tag stable while out_valid=1 and out_ready=0.

Reset
REQ-022 When reset=1 at a clock edge, s1_valid and s2_valid clear to 0; out_valid=0, imm=0, out_tag=0 at the next cycle.
REQ-023 Reset mid-operation discards all in-flight requests; in_ready=1 in the first cycle after reset deasserts.
REQ-024 Reset has priority over any simultaneous handshake.

Configuration
REQ-025 Macro IMM_GEN_ERR_EN: when defined, adds output out_err (1 bit), aligned with out_valid, =1 for illegal src; also adds a 16-bit saturating counter err_cnt output of illegal requests delivered, cleared by reset.
REQ-026 Without IMM_GEN_ERR_EN: out_err and err_cnt do not exist; illegal src yields imm=0 only.

Structure
REQ-027 Package imm_gen_pkg holds the SRC_I/S/B/U/J 3-bit encoding constants and the format enum typedef.
REQ-028 Sub-module imm_gen_decode holds the combinational extraction/extension (REQ-018..020), instantiated between S1 and S2.

Verification
REQ-029 XLEN=32, instr 0xFFF00093 (inm=0x1FFE001), src=000, out_ready=1 -> imm=0xFFFFFFFF two cycles after accept.
REQ-030 instr 0xFE000EE3, src=010 -> imm=0xFFFFFFFC; instr 0x123450B7, src=011 -> imm=0x12345000.
REQ-031 XLEN=64, instr 0x800000B7, src=011 -> imm=0xFFFFFFFF80000000.
REQ-032 Back-to-back 8 requests with tags 0..7, out_ready low for cycles 3-6 -> in_ready falls once S1 and S2 are full; results delivered in order with tags 0..7 and stable while stalled.
REQ-033 Reset pulse with 2 requests in flight -> out_valid=0 next cycle; neither result ever appears.
REQ-034 IMM_GEN_ERR_EN defined, src=110 -> imm=0, out_err=1, err_cnt increments by 1.
